// File: rtl/fwd_stall_ctrl_n_if.sv
// Decode-side bus for fwd_stall_ctrl_n: read ports, pipeline write-backs,
// long-latency unit events and the resolved operand / stall outputs.
interface fwd_stall_ctrl_n_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned NRD    = 2,
  parameter int unsigned CNT_W  = 16
);
  logic                    de_valid;
  logic                    de_is_long;
  logic [NRD*ADDR_W-1:0]   de_raddr;
  logic [NRD*DATA_W-1:0]   reg_rdata;
  logic                    exe_reg_en;
  logic [ADDR_W-1:0]       exe_reg_waddr;
  logic [DATA_W-1:0]       exe_reg_wdata;
  logic                    exe_mem_read;
  logic                    mem_reg_en;
  logic [ADDR_W-1:0]       mem_reg_waddr;
  logic [DATA_W-1:0]       mem_reg_wdata;
  logic                    wb_reg_en;
  logic [ADDR_W-1:0]       wb_reg_waddr;
  logic [DATA_W-1:0]       wb_reg_wdata;
  logic                    long_issue;
  logic [ADDR_W-1:0]       long_waddr;
  logic                    long_done;
  logic                    cnt_clr;
  logic [NRD*DATA_W-1:0]   de_rdata;
  logic                    stall;
  logic                    long_busy;
  logic [CNT_W-1:0]        stall_cnt;

  // Pipeline side: drives decode/stage information, consumes operands and stall.
  modport master (
    output de_valid, de_is_long, de_raddr, reg_rdata,
           exe_reg_en, exe_reg_waddr, exe_reg_wdata, exe_mem_read,
           mem_reg_en, mem_reg_waddr, mem_reg_wdata,
           wb_reg_en, wb_reg_waddr, wb_reg_wdata,
           long_issue, long_waddr, long_done, cnt_clr,
    input  de_rdata, stall, long_busy, stall_cnt
  );

  // Controller side.
  modport slave (
    input  de_valid, de_is_long, de_raddr, reg_rdata,
           exe_reg_en, exe_reg_waddr, exe_reg_wdata, exe_mem_read,
           mem_reg_en, mem_reg_waddr, mem_reg_wdata,
           wb_reg_en, wb_reg_waddr, wb_reg_wdata,
           long_issue, long_waddr, long_done, cnt_clr,
    output de_rdata, stall, long_busy, stall_cnt
  );
endinterface

// File: rtl/fwd_stall_ctrl_n.sv
// Decode-stage operand forwarding and stall control for NRD read ports.
// Forwards from EXE/MEM/WB, tracks one in-flight long-latency (divider)
// result with a single-entry scoreboard, and counts stalled cycles.
module fwd_stall_ctrl_n #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned NRD    = 2,
  parameter int unsigned CNT_W  = 16
) (
  input logic              clk,
  input logic              rst,
  fwd_stall_ctrl_n_if.slave bus
);

  logic                  busy_q;
  logic [ADDR_W-1:0]     pwaddr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [NRD*DATA_W-1:0] rdata_c;
  logic [NRD-1:0]        lu_hit;
  logic [NRD-1:0]        lr_hit;
  logic                  busy_eff;
  logic                  load_use;
  logic                  long_raw;
  logic                  struct_hz;
  logic                  stall_c;

  // Per-port operand resolution (EXE > MEM > WB > regfile, r0 reads zero)
  // and per-port address matches against the load and scoreboard entries.
  always_comb begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    a       = '0;
    d       = '0;
    rdata_c = '0;
    lu_hit  = '0;
    lr_hit  = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      a = bus.de_raddr[i*ADDR_W +: ADDR_W];
      if (a == '0)
        d = '0;
      else if (bus.exe_reg_en && (bus.exe_reg_waddr == a))
        d = bus.exe_reg_wdata;
      else if (bus.mem_reg_en && (bus.mem_reg_waddr == a))
        d = bus.mem_reg_wdata;
      else if (bus.wb_reg_en && (bus.wb_reg_waddr == a))
        d = bus.wb_reg_wdata;
      else
        d = bus.reg_rdata[i*DATA_W +: DATA_W];
      rdata_c[i*DATA_W +: DATA_W] = d;
      lu_hit[i] = (a == bus.exe_reg_waddr);
      lr_hit[i] = (a == pwaddr_q);
    end
  end

  // Hazard detection; a retiring long result is forwarded via WB, so it
  // no longer counts as busy in its done cycle.
  always_comb begin
    busy_eff  = busy_q & ~bus.long_done;
    load_use  = bus.de_valid & bus.exe_mem_read & bus.exe_reg_en &
                (bus.exe_reg_waddr != '0) & (|lu_hit);
    long_raw  = bus.de_valid & busy_eff & (pwaddr_q != '0) & (|lr_hit);
    struct_hz = bus.de_valid & bus.de_is_long & busy_eff;
    stall_c   = load_use | long_raw | struct_hz;
  end

  // Single-entry scoreboard for the long-latency unit; issue beats done.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      pwaddr_q <= '0;
    end else if (bus.long_issue) begin
      busy_q   <= 1'b1;
      pwaddr_q <= bus.long_waddr;
    end else if (bus.long_done) begin
      busy_q   <= 1'b0;
    end
  end

  // Saturating stall-cycle counter; clear beats increment.
  always_ff @(posedge clk) begin
    if (rst || bus.cnt_clr)
      cnt_q <= '0;
    else if (stall_c && (cnt_q != '1))
      cnt_q <= cnt_q + CNT_W'(1);
  end

  assign bus.de_rdata  = rdata_c;
  assign bus.stall     = stall_c;
  assign bus.long_busy = busy_q;
  assign bus.stall_cnt = cnt_q;

endmodule
